uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver: recovers 8-bit frames (1 start, 8 data LSB-first, 1 stop) from an asynchronous serial line and presents each byte as a one-cycle strobe on the system clock. It is the downstream counterpart of the team's UART transmitter and consumes its `tx` line directly, with the same frame format. It runs entirely on `clk`; there is no derived bit clock.

## Interface
- `CLK_FREQ`, 1000000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bit/s.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rx`  in  1  asynchronous serial input, idle high.
- `rx_data`  out  8  last good byte received.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` updated.
- `rx_busy`  out  1  high while a frame is in progress (START through STOP).
- `frame_err`  out  1  one-cycle strobe: the stop bit sampled 0.
- `parity_err`  out  1  one-cycle strobe: parity mismatch. Present only when `UART_RX_PARITY_EN` is defined.

## Operation
- Bit period and counter sizing:
  - `CPB = CLK_FREQ/BAUD_RATE`, using integer floor (104 at defaults).
  - `HALF = CPB/2` (52 at defaults).
  - Bit counter width is `$clog2(CPB)`.
  - `CPB >= 4` is required; otherwise elaboration fails via `$error`.
- Input synchronizer:
  - `rx` passes through a 2-flop synchronizer (`rx_s`).
  - Both flops reset to 1.
  - All decisions below use `rx_s`.
- States: WAIT_HIGH, IDLE, START, DATA, (PARITY), STOP.
  - **WAIT_HIGH**: go to IDLE when `rx_s == 1`. This is the reset state, so a line held low at reset exit is not mistaken for a start bit.
  - **IDLE**: on `rx_s == 0`, clear the counter and go to START.
  - **START**: count to `HALF-1`.
    - If `rx_s == 0` there, clear the counter and clear the bit index, then go to DATA.
    - Otherwise go to IDLE; the event is treated as a glitch and nothing is reported.
  - **DATA**: at counter `CPB-1`, sample `rx_s` into `shift[idx]`, where `idx` runs 0..7, and clear the counter.
    - After `idx == 7`, go to STOP, or to PARITY when `UART_RX_PARITY_EN` is defined.
  - **PARITY** (macro only): at `CPB-1`, sample the parity bit and clear the counter, then go to STOP.
  - **STOP**: at `CPB-1`, sample `rx_s`.
    - If 1: `rx_data <= shift` and `rx_valid <= 1` for one cycle, then go to IDLE.
    - If 0: `frame_err <= 1` for one cycle, `rx_data` is unchanged, `rx_valid` stays 0, then go to WAIT_HIGH (break or misframe).
- `rx_busy = 1` in START, DATA, PARITY and STOP.
- Strobes: `rx_valid` and `frame_err` are never high in the same cycle.
- There is no flow control. A consumer that ignores a strobe loses that byte.

## Timing
- Reset values:
  - `rx_data = 8'h00`
  - `rx_valid = 0`
  - `rx_busy = 0`
  - `frame_err = 0`
  - `parity_err = 0`
  - state = WAIT_HIGH
- Reset mid-frame: the frame is discarded and nothing is strobed. The receiver waits for `rx_s == 1`.
- Latency: let t0 be the first cycle `rx_s == 0` is seen in IDLE, which is 2 cycles after the `rx` falling edge.
  - Without the macro, `rx_valid`/`frame_err` is high in cycle `t0 + HALF + 9*CPB + 1`, which is 989 at defaults.
  - With the macro, the same strobes come one `CPB` later.
- Data bit k is sampled at `t0 + HALF + (k+1)*CPB`, i.e. mid-bit.
- Back-to-back frames: a start bit immediately following the stop bit is accepted. STOP returns to IDLE one cycle after its sample, which is roughly `HALF` cycles before the stop bit ends.

## Configuration
- `UART_RX_PARITY_EN`, defined:
  - The frame carries one even-parity bit after `d7`.
  - The PARITY state and the `parity_err` port exist.
  - On a mismatch with a good stop bit, `parity_err` pulses in the STOP-decision cycle, `rx_valid` is suppressed and `rx_data` is unchanged.
  - A bad stop bit reports `frame_err` only.
- `UART_RX_PARITY_EN`, undefined:
  - The frame has 10 bits, there is no PARITY state and no `parity_err` port.

## Test plan
- Defaults, drive 0xA5 at 104 clk/bit after the line has idled high: exactly one `rx_valid` pulse, in cycle `t0+989`, with `rx_data == 8'hA5`; `frame_err` stays 0.
- Back-to-back 0x00 then 0xFF, each with one stop bit and no idle gap: two `rx_valid` pulses 1040 cycles apart, with `rx_data` reading 8'h00 then 8'hFF.
- `rx` low for 20 cycles, then high: `rx_busy` is high for at most `HALF` cycles; no `rx_valid`, no `frame_err`.
- Frame 0x55 with stop bit driven 0 and the line held low for 2000 cycles, then high, then 0x3C: one `frame_err` pulse and `rx_data` unchanged; no activity while the line is low; then `rx_valid` with 8'h3C.
- `rst` pulsed during data bit 4 of 0x81: no strobes for that frame, all outputs at their reset values. The next clean 0x81 is received correctly.
- With `UART_RX_PARITY_EN` defined, send 0x07 with parity bit 1 (correct) and then with parity bit 0 (wrong): the first gives `rx_valid` with 8'h07; the second gives one `parity_err` pulse, no `rx_valid`, and `rx_data` still 8'h07.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames (plus one even-parity bit when UART_RX_PARITY_EN is defined),
// oversampled on clk with mid-bit sampling and one-cycle rx_valid/frame_err strobes.
module uart_rx #(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
`ifdef UART_RX_PARITY_EN
  output logic       frame_err,
  output logic       parity_err
`else
  output logic       frame_err
`endif
);

  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  if (CPB < 4) begin : g_bad_cpb
    $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
  end

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state, state_next;
  logic          rx_meta, rx_s;
  logic [1:0]    sync_ok;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          cnt_clr, sample_data, stop_ok, stop_bad;
`ifdef UART_RX_PARITY_EN
  logic          sample_par, par_bit, par_bad;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_HIGH;
    else     state <= state_next;
  end

  // sync_ok keeps WAIT_HIGH from trusting the reset value of the synchronizer
  // until real line samples have propagated through both flops.
  always_comb begin
    state_next  = state;
    cnt_clr     = 1'b0;
    sample_data = 1'b0;
    stop_ok     = 1'b0;
    stop_bad    = 1'b0;
`ifdef UART_RX_PARITY_EN
    sample_par  = 1'b0;
`endif
    case (state)
      WAIT_HIGH: if (rx_s && sync_ok[1]) state_next = IDLE;
      IDLE: if (!rx_s) begin
        cnt_clr    = 1'b1;
        state_next = START;
      end
      START: if (cnt == HALF_LAST) begin
        if (!rx_s) begin
          cnt_clr    = 1'b1;
          state_next = DATA;
        end else begin
          state_next = IDLE;
        end
      end
      DATA: if (cnt == CNT_LAST) begin
        cnt_clr     = 1'b1;
        sample_data = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (idx == 3'd7) state_next = PARITY;
`else
        if (idx == 3'd7) state_next = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt == CNT_LAST) begin
        cnt_clr    = 1'b1;
        sample_par = 1'b1;
        state_next = STOP;
      end
`endif
      STOP: if (cnt == CNT_LAST) begin
        cnt_clr = 1'b1;
        if (rx_s) begin
          stop_ok    = 1'b1;
          state_next = IDLE;
        end else begin
          stop_bad   = 1'b1;
          state_next = WAIT_HIGH;
        end
      end
      default: state_next = WAIT_HIGH;
    endcase
  end

  assign rx_busy = (state != WAIT_HIGH) && (state != IDLE);

`ifdef UART_RX_PARITY_EN
  assign par_bad = (par_bit != ^shift);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      sync_ok    <= 2'b00;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      sync_ok   <= {sync_ok[0], 1'b1};
      cnt       <= cnt_clr ? '0 : cnt + 1'b1;
      if (state == START)   idx <= '0;
      else if (sample_data) idx <= idx + 3'd1;
      if (sample_data) shift[idx] <= rx_s;
      frame_err <= stop_bad;
`ifdef UART_RX_PARITY_EN
      if (sample_par) par_bit <= rx_s;
      rx_valid   <= stop_ok && !par_bad;
      parity_err <= stop_ok && par_bad;
      if (stop_ok && !par_bad) rx_data <= shift;
`else
      rx_valid <= stop_ok;
      if (stop_ok) rx_data <= shift;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, corner sequences and random frames
// compared against a frame-level timing/data model; parity cases only with UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int CLK_FREQ  = 1000000;
  localparam int BAUD_RATE = 9600;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int HALF      = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Bit periods from start-bit edge to the stop-bit sample point
  localparam int NBITS = PAR_EN ? 10 : 9;

  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_PERR  = 2;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         low_after;
    int         idle_after;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] model_last = 8'h00;
  ev_t        exp_q[$];
  ev_t        got_q[$];
  vec_t       tbl[5];

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
`ifdef UART_RX_PARITY_EN
    .frame_err (frame_err),
    .parity_err(parity_err)
`else
    .frame_err (frame_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Strobes are logged on the falling edge, away from the DUT's active edge
  always @(negedge clk) begin
    if (rx_valid || frame_err) check_output("valid/frame_err exclusive", rx_valid & frame_err, 0);
    if (rx_valid)  got_q.push_back('{cyc, K_VALID, rx_data});
    if (frame_err) got_q.push_back('{cyc, K_FERR, rx_data});
`ifdef UART_RX_PARITY_EN
    if (parity_err) got_q.push_back('{cyc, K_PERR, rx_data});
`endif
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Sends one frame starting now; the model predicts the strobe from the start-bit edge
  task automatic apply_stimulus(input logic [7:0] d, input logic stop_bit, input logic par_flip,
                                input int low_after, input int idle_after, input bit push_model);
    ev_t e;
    if (push_model) begin
      e.cyc = cyc + 3 + HALF + NBITS * CPB;
      if (!stop_bit) begin
        e.kind = K_FERR;
        e.data = model_last;
      end else if (PAR_EN && par_flip) begin
        e.kind = K_PERR;
        e.data = model_last;
      end else begin
        e.kind = K_VALID;
        e.data = d;
        model_last = d;
      end
      exp_q.push_back(e);
    end
    drive_bit(1'b0);
    for (int k = 0; k < 8; k++) drive_bit(d[k]);
    if (PAR_EN) drive_bit((^d) ^ par_flip);
    drive_bit(stop_bit);
    if (low_after > 0) begin
      rx = 1'b0;
      repeat (low_after / 2) @(negedge clk);
      check_output("busy while line low", rx_busy, 0);
      repeat (low_after - low_after / 2) @(negedge clk);
    end
    rx = 1'b1;
    repeat (idle_after) @(negedge clk);
  endtask

  task automatic check_events(input string name);
    ev_t e, g;
    repeat (10) @(negedge clk);
    check_output({name, " strobe count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check_output({name, " strobe cycle"}, g.cyc, e.cyc);
      check_output({name, " strobe kind"}, g.kind, e.kind);
      check_output({name, " strobe data"}, g.data, e.data);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic check_reset_values(input string name);
    check_output({name, " rx_data"}, rx_data, 8'h00);
    check_output({name, " rx_valid"}, rx_valid, 0);
    check_output({name, " rx_busy"}, rx_busy, 0);
    check_output({name, " frame_err"}, frame_err, 0);
`ifdef UART_RX_PARITY_EN
    check_output({name, " parity_err"}, parity_err, 0);
`endif
  endtask

  initial begin
    int         busy;
    int         fall;
    logic [7:0] d;
    logic       stop;
    logic       pf;

    tbl[0] = '{8'hA5, 1'b1, 0,    300, 8'hA5, 1'b1, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 0,    0,   8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 0,    300, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h55, 1'b0, 1900, 300, 8'hFF, 1'b0, 1'b1};
    tbl[4] = '{8'h3C, 1'b1, 0,    300, 8'h3C, 1'b1, 1'b0};

    repeat (4) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    repeat (50) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      fall = cyc;
      if (tbl[i].exp_valid || tbl[i].exp_ferr)
        exp_q.push_back('{fall + 3 + HALF + NBITS * CPB, tbl[i].exp_valid ? K_VALID : K_FERR, tbl[i].exp_data});
      if (tbl[i].exp_valid) model_last = tbl[i].exp_data;
      apply_stimulus(tbl[i].data, tbl[i].stop, 1'b0, tbl[i].low_after, tbl[i].idle_after, 1'b0);
    end
    check_events("table");
    check_output("rx_data after table", rx_data, 8'h3C);

    busy = 0;
    rx = 1'b0;
    for (int i = 0; i < 220; i++) begin
      if (i == 20) rx = 1'b1;
      @(negedge clk);
      if (rx_busy) busy++;
    end
    check_output("glitch busy within 1..HALF", (busy > 0) && (busy <= HALF), 1);
    check_events("glitch");

    d = 8'h81;
    drive_bit(1'b0);
    for (int k = 0; k < 4; k++) drive_bit(d[k]);
    rx = d[4];
    repeat (HALF) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("mid-frame reset");
    rst = 1'b0;
    model_last = 8'h00;
    repeat (CPB - HALF - 1) @(negedge clk);
    for (int k = 5; k < 8; k++) drive_bit(d[k]);
    drive_bit(1'b1);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    check_events("mid-frame reset");
    apply_stimulus(8'h81, 1'b1, 1'b0, 0, 300, 1'b1);
    check_events("after reset");
    check_output("rx_data after reset", rx_data, 8'h81);

    for (int i = 0; i < 15; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      pf   = PAR_EN && ($urandom_range(0, 4) == 0);
      if (stop) apply_stimulus(d, 1'b1, pf, 0, $urandom_range(0, 150), 1'b1);
      else      apply_stimulus(d, 1'b0, pf, $urandom_range(100, 600), $urandom_range(20, 150), 1'b1);
    end
    check_events("random");
    check_output("rx_data after random", rx_data, model_last);

`ifdef UART_RX_PARITY_EN
    apply_stimulus(8'h07, 1'b1, 1'b0, 0, 200, 1'b1);
    apply_stimulus(8'h07, 1'b1, 1'b1, 0, 200, 1'b1);
    check_events("parity");
    check_output("rx_data after parity error", rx_data, 8'h07);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
